mdu: RTL and testbench
======================

Name: mdu

Overview:
- Multiply/divide unit that sits beside the ALU in the EX stage of the multi-cycle-capable MIPS pipeline.
- Consumes the same rs/rt GPR read data the ALU uses and owns the architectural HI/LO registers.
- Executes mult, multu, div, divu, mthi and mtlo.
- Raises busy so hazard logic can stall mfhi/mflo and any following MD instruction.

Parameters:
- MUL_LAT, 5: cycles busy stays high for mult/multu (product computed once, result delayed by counter).
- DIV_LAT, 33: cycles busy stays high for div/divu (1 operand-latch cycle, 32 restoring iterations, sign fixup at write edge); fixed by the iterative core, not free to change.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous active-high reset
- start  input  1  one-cycle request, qualified by md_op
- md_op  input  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo, 111 reserved (treated as none)
- a  input  32  rs operand (dividend / multiplicand / mthi-mtlo source)
- b  input  32  rt operand (divisor / multiplier)
- busy  output  1  operation in flight
- hi  output  32  HI register
- lo  output  32  LO register

Behaviour:
- Reset (sync, active-high, priority over everything): hi=0, lo=0, busy=0, counter=0, FSM=IDLE. Reset mid-operation aborts it; no HI/LO write occurs.
- FSM states: IDLE, MUL, DIV.
- IDLE with start=1 and op mult/multu/div/divu: latch operands and sign info at that edge (E0), set busy=1, enter MUL or DIV.
- MUL/DIV: counter runs. At edge E_L (L = MUL_LAT or DIV_LAT) write HI/LO, busy=0, return to IDLE. busy is high for exactly L cycles.
- The stall condition upstream is (start & md op) | busy. The block does not assert busy combinationally from start.
- start while busy=1 is ignored: no operand latch, no HI/LO change. Hazard logic guarantees this never happens in normal flow.
- mthi/mtlo in IDLE: hi<=a or lo<=a at that edge; busy stays 0. Ignored while busy.
- md_op none or reserved with start=1: no effect.
- mult: 64-bit signed product of a×b; HI=[63:32], LO=[31:0].
- multu: same as mult, unsigned.
- divu: iterative restoring division on 32-bit unsigned values; LO=quotient, HI=remainder.
- div: divide |a| by |b| unsigned.
  - Quotient is negated if the signs differ, so it truncates toward zero.
  - Remainder takes the sign of the dividend.
- Overflow case: div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0. No trap.
- Divide by zero (b=0, div or divu): runs the full DIV_LAT; HI and LO are left unchanged.
- hi/lo are register outputs, readable every cycle. During an operation they hold their previous values until the write edge.

Decomposition:
- Shared package mdu_pkg holds:
  - md_op encodings (MD_NONE … MD_MTLO)
  - MUL_LAT and DIV_LAT defaults
  - FSM state encodings
- One sub-module, div_iter: a 32-iteration unsigned restoring divider core.
  - Inputs: start, dividend, divisor.
  - Outputs: quotient, remainder, done.
  - mdu owns abs/sign fixup and the multiply path.

Test Plan:
- mult a=0xFFFFFFFF, b=0x00000002: busy high 5 cycles → hi=0xFFFFFFFF, lo=0xFFFFFFFE. multu with the same operands → hi=0x00000001, lo=0xFFFFFFFE.
- div a=0xFFFFFFF9 (-7), b=2: busy high 33 cycles → lo=0xFFFFFFFD, hi=0xFFFFFFFF. divu a=7, b=2 → lo=3, hi=1.
- Preload hi=0x11111111 and lo=0x22222222 via mthi/mtlo, then div b=0 → after 33 cycles hi/lo unchanged, busy=0.
- div a=0x80000000, b=0xFFFFFFFF → lo=0x80000000, hi=0.
- Start mult, then pulse start with divu and also mthi a=0xDEADBEEF during busy → both ignored; final hi/lo equal the mult result.
- Start div, assert reset at cycle 10 → next edge busy=0, hi=0, lo=0, FSM=IDLE. A subsequent multu 3×4 gives lo=12, hi=0.

Source files
------------

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: op encodings, latencies, FSM states.
package mdu_pkg;

  typedef enum logic [2:0] {
    MD_NONE  = 3'd0,
    MD_MULT  = 3'd1,
    MD_MULTU = 3'd2,
    MD_DIV   = 3'd3,
    MD_DIVU  = 3'd4,
    MD_MTHI  = 3'd5,
    MD_MTLO  = 3'd6,
    MD_RSVD  = 3'd7
  } md_op_e;

  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 33;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } md_state_e;

  function automatic logic [31:0] cond_neg(input logic neg, input logic [31:0] v);
    return neg ? (~v + 32'd1) : v;
  endfunction

endpackage

// File: rtl/div_iter.sv
// 32-iteration unsigned restoring divider: loads on start, one quotient bit per cycle,
// done rises after the 32nd iteration and holds until the next start.
module div_iter (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done
);

  logic [31:0] rem_q, quo_q, dsr_q;
  logic [5:0]  iter_q;
  logic        run_q;
  logic [32:0] rem_sh, diff;

  // Partial remainder stays below the divisor, so 33 bits hold the shifted trial value.
  assign rem_sh = {rem_q, quo_q[31]};
  assign diff   = rem_sh - {1'b0, dsr_q};

  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q  <= '0;
      quo_q  <= '0;
      dsr_q  <= '0;
      iter_q <= '0;
      run_q  <= 1'b0;
    end else if (start) begin
      rem_q  <= '0;
      quo_q  <= dividend;
      dsr_q  <= divisor;
      iter_q <= '0;
      run_q  <= 1'b1;
    end else if (run_q && iter_q != 6'd32) begin
      if (!diff[32]) begin
        rem_q <= diff[31:0];
        quo_q <= {quo_q[30:0], 1'b1};
      end else begin
        rem_q <= rem_sh[31:0];
        quo_q <= {quo_q[30:0], 1'b0};
      end
      iter_q <= iter_q + 6'd1;
    end
  end

  assign quotient  = quo_q;
  assign remainder = rem_q;
  assign done      = run_q && (iter_q == 6'd32);

endmodule

// File: rtl/mdu.sv
// EX-stage multiply/divide unit owning HI/LO; busy covers the whole operation so hazard
// logic can stall dependent instructions. Signed divide wraps the unsigned core with abs/sign fixup.
module mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [5:0] MUL_L = MUL_LAT[5:0];
  localparam logic [5:0] DIV_L = DIV_LAT[5:0];

  md_state_e   state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic [63:0] prod_q, prod_d;
  logic        negq_q, negq_d, negr_q, negr_d, divz_q, divz_d;

  logic        div_start, div_done, sdiv, smul;
  logic [31:0] a_abs, b_abs, div_quo, div_rem;
  logic [63:0] mul_full;

  assign sdiv  = (md_op == MD_DIV);
  assign smul  = (md_op == MD_MULT);
  assign a_abs = cond_neg(sdiv & a[31], a);
  assign b_abs = cond_neg(sdiv & b[31], b);
  // One 64x64 multiplier serves both flavours; only the extension bits differ.
  assign mul_full = {{32{smul & a[31]}}, a} * {{32{smul & b[31]}}, b};

  div_iter u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start),
    .dividend  (a_abs),
    .divisor   (b_abs),
    .quotient  (div_quo),
    .remainder (div_rem),
    .done      (div_done)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    prod_d    = prod_q;
    negq_d    = negq_q;
    negr_d    = negr_q;
    divz_d    = divz_q;
    div_start = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          case (md_op)
            MD_MULT, MD_MULTU: begin
              prod_d  = mul_full;
              cnt_d   = 6'd1;
              state_d = ST_MUL;
            end
            MD_DIV, MD_DIVU: begin
              div_start = 1'b1;
              negq_d    = sdiv & (a[31] ^ b[31]);
              negr_d    = sdiv & a[31];
              divz_d    = (b == 32'd0);
              cnt_d     = 6'd1;
              state_d   = ST_DIV;
            end
            MD_MTHI: hi_d = a;
            MD_MTLO: lo_d = a;
            default: ;
          endcase
        end
      end
      ST_MUL: begin
        if (cnt_q == MUL_L) begin
          hi_d    = prod_q[63:32];
          lo_d    = prod_q[31:0];
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      ST_DIV: begin
        if (cnt_q == DIV_L && div_done) begin
          // A zero divisor still spends the full latency but leaves HI/LO untouched.
          if (!divz_q) begin
            lo_d = cond_neg(negq_q, div_quo);
            hi_d = cond_neg(negr_q, div_rem);
          end
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      prod_q  <= '0;
      negq_q  <= 1'b0;
      negr_q  <= 1'b0;
      divz_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      prod_q  <= prod_d;
      negq_q  <= negq_d;
      negr_q  <= negr_d;
      divz_q  <= divz_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign hi   = hi_q;
  assign lo   = lo_q;

endmodule

// File: tb/tb_mdu.sv
// Bench for mdu: arithmetic reference model checked every cycle plus literal test-plan checks.
module tb_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start;
  logic [2:0]  md_op;
  logic [31:0] a, b;
  logic        busy;
  logic [31:0] hi, lo;

  always #5 clk = ~clk;

  mdu dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .md_op (md_op),
    .a     (a),
    .b     (b),
    .busy  (busy),
    .hi    (hi),
    .lo    (lo)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Reference model: result is computed at acceptance and committed L edges later.
  logic [31:0] m_hi, m_lo, p_hi, p_lo;
  int          m_rem = 0;
  bit          p_wr = 0;
  bit          m_valid = 0;
  longint      sp, sq, sr;
  logic [63:0] up;

  always @(posedge clk) begin
    if (reset) begin
      m_hi = '0; m_lo = '0; m_rem = 0; p_wr = 0; m_valid = 1;
    end else if (m_rem > 0) begin
      m_rem--;
      if (m_rem == 0 && p_wr) begin
        m_hi = p_hi;
        m_lo = p_lo;
      end
    end else if (start) begin
      case (md_op)
        MD_MULT: begin
          sp = longint'(signed'(a)) * longint'(signed'(b));
          {p_hi, p_lo} = sp;
          p_wr = 1; m_rem = 5;
        end
        MD_MULTU: begin
          up = {32'd0, a} * {32'd0, b};
          {p_hi, p_lo} = up;
          p_wr = 1; m_rem = 5;
        end
        MD_DIVU: begin
          p_wr = (b != 0); m_rem = 33;
          if (b != 0) begin
            p_lo = a / b;
            p_hi = a % b;
          end
        end
        MD_DIV: begin
          p_wr = (b != 0); m_rem = 33;
          if (b != 0) begin
            sq = longint'(signed'(a)) / longint'(signed'(b));
            sr = longint'(signed'(a)) % longint'(signed'(b));
            p_lo = sq[31:0];
            p_hi = sr[31:0];
          end
        end
        MD_MTHI: m_hi = a;
        MD_MTLO: m_lo = a;
        default: ;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("cyc_busy", 64'(busy), 64'(m_rem > 0));
      check("cyc_hi", 64'(hi), 64'(m_hi));
      check("cyc_lo", 64'(lo), 64'(m_lo));
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv);
    @(negedge clk);
    start = 1'b1; md_op = op; a = av; b = bv;
    @(negedge clk);
    start = 1'b0; md_op = MD_NONE;
  endtask

  task automatic count_busy(output int n);
    n = 0;
    while (busy && n < 100) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("wait_idle_timeout", 64'(busy), 64'd0);
  endtask

  int n;
  logic [2:0]  rop;
  logic [31:0] ra, rb;

  initial begin
    reset = 1'b1; start = 1'b0; md_op = MD_NONE; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("reset_busy", 64'(busy), 64'd0);
    check("reset_hi", 64'(hi), 64'd0);
    check("reset_lo", 64'(lo), 64'd0);
    reset = 1'b0;

    issue(MD_MULT, 32'hFFFF_FFFF, 32'h0000_0002);
    count_busy(n);
    check("mult_busy_len", 64'(n), 64'd5);
    check("mult_hi", 64'(hi), 64'hFFFF_FFFF);
    check("mult_lo", 64'(lo), 64'hFFFF_FFFE);

    issue(MD_MULTU, 32'hFFFF_FFFF, 32'h0000_0002);
    wait_idle();
    check("multu_hi", 64'(hi), 64'h0000_0001);
    check("multu_lo", 64'(lo), 64'hFFFF_FFFE);

    issue(MD_DIV, 32'hFFFF_FFF9, 32'd2);
    count_busy(n);
    check("div_busy_len", 64'(n), 64'd33);
    check("div_lo", 64'(lo), 64'hFFFF_FFFD);
    check("div_hi", 64'(hi), 64'hFFFF_FFFF);

    issue(MD_DIVU, 32'd7, 32'd2);
    wait_idle();
    check("divu_lo", 64'(lo), 64'd3);
    check("divu_hi", 64'(hi), 64'd1);

    issue(MD_MTHI, 32'h1111_1111, 32'd0);
    check("mthi_nobusy", 64'(busy), 64'd0);
    check("mthi_hi", 64'(hi), 64'h1111_1111);
    issue(MD_MTLO, 32'h2222_2222, 32'd0);
    check("mtlo_lo", 64'(lo), 64'h2222_2222);
    issue(MD_DIV, 32'd5, 32'd0);
    count_busy(n);
    check("div0_busy_len", 64'(n), 64'd33);
    check("div0_hi", 64'(hi), 64'h1111_1111);
    check("div0_lo", 64'(lo), 64'h2222_2222);

    issue(MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_idle();
    check("divovf_lo", 64'(lo), 64'h8000_0000);
    check("divovf_hi", 64'(hi), 64'd0);

    issue(MD_MULT, 32'h0000_1234, 32'h0000_0010);
    issue(MD_DIVU, 32'd100, 32'd7);
    issue(MD_MTHI, 32'hDEAD_BEEF, 32'd0);
    wait_idle();
    check("ignored_hi", 64'(hi), 64'd0);
    check("ignored_lo", 64'(lo), 64'h0001_2340);

    issue(MD_DIV, 32'd1000, 32'd3);
    repeat (8) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("abort_busy", 64'(busy), 64'd0);
    check("abort_hi", 64'(hi), 64'd0);
    check("abort_lo", 64'(lo), 64'd0);
    reset = 1'b0;
    issue(MD_MULTU, 32'd3, 32'd4);
    wait_idle();
    check("post_rst_lo", 64'(lo), 64'd12);
    check("post_rst_hi", 64'(hi), 64'd0);

    for (int i = 0; i < 200; i++) begin
      rop = 3'($urandom_range(0, 7));
      case ($urandom_range(0, 3))
        0: ra = 32'h8000_0000;
        1: ra = 32'($urandom_range(0, 50));
        default: ra = $urandom;
      endcase
      case ($urandom_range(0, 4))
        0: rb = 32'd0;
        1: rb = 32'hFFFF_FFFF;
        2: rb = 32'($urandom_range(1, 20));
        default: rb = $urandom;
      endcase
      issue(rop, ra, rb);
      if (busy && $urandom_range(0, 3) == 0)
        issue(3'($urandom_range(0, 7)), $urandom, $urandom);
      wait_idle();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
